vga_timing_gen: RTL

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

---
 rtl/vga_timing_gen.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel-rate strobe, h/v counters, registered syncs and active-area coordinates.
// Optional one-pixel lookahead outputs (xNext/yNext/nextOn) are built when VGA_LOOKAHEAD_EN is defined.
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int CLK_DIV  = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  output logic                        pixTick,
  output logic                        hSync,
  output logic                        vSync,
  output logic                        videoOn,
  output logic [$clog2(H_ACTIVE)-1:0] xPos,
  output logic [$clog2(V_ACTIVE)-1:0] yPos,
  output logic                        frameStart,
  output logic [$clog2(H_ACTIVE)-1:0] xNext,
  output logic [$clog2(V_ACTIVE)-1:0] yNext,
  output logic                        nextOn
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int XW  = $clog2(H_ACTIVE);
  localparam int YW  = $clog2(V_ACTIVE);
  localparam int HCW = $clog2(H_TOTAL);
  localparam int VCW = $clog2(V_TOTAL);
  localparam int DW  = $clog2(CLK_DIV);

  localparam logic [DW-1:0]  DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [HCW-1:0] H_LAST   = HCW'(H_TOTAL - 1);
  localparam logic [HCW-1:0] H_ACT    = HCW'(H_ACTIVE);
  localparam logic [HCW-1:0] HS_BEG   = HCW'(H_ACTIVE + H_FP);
  localparam logic [HCW-1:0] HS_END   = HCW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VCW-1:0] V_LAST   = VCW'(V_TOTAL - 1);
  localparam logic [VCW-1:0] V_ACT    = VCW'(V_ACTIVE);
  localparam logic [VCW-1:0] VS_BEG   = VCW'(V_ACTIVE + V_FP);
  localparam logic [VCW-1:0] VS_END   = VCW'(V_ACTIVE + V_FP + V_SYNC);

  function automatic logic is_on(input logic [HCW-1:0] h, input logic [VCW-1:0] v);
    return (h < H_ACT) && (v < V_ACT);
  endfunction

  function automatic logic [XW-1:0] col_of(input logic [HCW-1:0] h, input logic [VCW-1:0] v);
    return is_on(h, v) ? h[XW-1:0] : '0;
  endfunction

  function automatic logic [YW-1:0] row_of(input logic [HCW-1:0] h, input logic [VCW-1:0] v);
    return is_on(h, v) ? v[YW-1:0] : '0;
  endfunction

  logic [DW-1:0]  r_div, w_div_next;
  logic [HCW-1:0] r_h, w_h_next;
  logic [VCW-1:0] r_v, w_v_next;
  logic           w_tick;
  logic           r_pix, r_fs, r_hs, r_vs, r_on;
  logic [XW-1:0]  r_x;
  logic [YW-1:0]  r_y;

  always_comb begin
    w_tick     = (r_div == DIV_LAST);
    w_div_next = w_tick ? '0 : r_div + 1'b1;
    w_h_next   = r_h;
    w_v_next   = r_v;
    if (w_tick) begin
      if (r_h == H_LAST) begin
        w_h_next = '0;
        w_v_next = (r_v == V_LAST) ? '0 : r_v + 1'b1;
      end else begin
        w_h_next = r_h + 1'b1;
      end
    end
  end

  // Outputs are decoded from next-state counters so they land on the same edge as the counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_div <= '0;
      r_h   <= '0;
      r_v   <= '0;
      r_pix <= 1'b0;
      r_fs  <= 1'b0;
      r_hs  <= 1'b1;
      r_vs  <= 1'b1;
      r_on  <= 1'b1;
      r_x   <= '0;
      r_y   <= '0;
    end else begin
      r_div <= w_div_next;
      r_h   <= w_h_next;
      r_v   <= w_v_next;
      r_pix <= (w_div_next == DIV_LAST);
      r_fs  <= (w_div_next == DIV_LAST) && (w_h_next == H_LAST) && (w_v_next == V_LAST);
      r_hs  <= ~((w_h_next >= HS_BEG) && (w_h_next < HS_END));
      r_vs  <= ~((w_v_next >= VS_BEG) && (w_v_next < VS_END));
      r_on  <= is_on(w_h_next, w_v_next);
      r_x   <= col_of(w_h_next, w_v_next);
      r_y   <= row_of(w_h_next, w_v_next);
    end
  end

  assign pixTick    = r_pix;
  assign frameStart = r_fs;
  assign hSync      = r_hs;
  assign vSync      = r_vs;
  assign videoOn    = r_on;
  assign xPos       = r_x;
  assign yPos       = r_y;

`ifdef VGA_LOOKAHEAD_EN
  logic [HCW-1:0] w_h_la;
  logic [VCW-1:0] w_v_la;
  logic           r_non;
  logic [XW-1:0]  r_xn;
  logic [YW-1:0]  r_yn;

  // Position one pixel beyond the next counter state, wrapping across line and frame ends.
  always_comb begin
    w_h_la = (w_h_next == H_LAST) ? '0 : w_h_next + 1'b1;
    w_v_la = w_v_next;
    if (w_h_next == H_LAST) begin
      w_v_la = (w_v_next == V_LAST) ? '0 : w_v_next + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_non <= 1'b0;
      r_xn  <= '0;
      r_yn  <= '0;
    end else begin
      r_non <= is_on(w_h_la, w_v_la);
      r_xn  <= col_of(w_h_la, w_v_la);
      r_yn  <= row_of(w_h_la, w_v_la);
    end
  end

  assign nextOn = r_non;
  assign xNext  = r_xn;
  assign yNext  = r_yn;
`else
  assign nextOn = 1'b0;
  assign xNext  = '0;
  assign yNext  = '0;
`endif
endmodule
